// File: rtl/axi_host_mem_responder.sv
// axi_host_mem_responder: AXI4 slave backed by a small word RAM, standing in for host memory on m_axi_gmem.
// One outstanding INCR burst per direction; illegal bursts are handshaken but answered with SLVERR.
module axi_host_mem_responder #(
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 1024,
  parameter int MEM_DEPTH_LOG2 = 6
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [31:0]               wr_burst_cnt,
  output logic [31:0]               rd_burst_cnt,
  output logic                      err_sticky
);
  localparam int OFS = $clog2(DATA_WIDTH/8);
  localparam int SW = DATA_WIDTH/8;
  localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = 1;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];
  logic [MEM_DEPTH_LOG2-1:0] w_idx, r_idx, aw_idx, ar_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_legal, w_bad, r_legal, aw_legal, ar_legal;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_final;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};
  assign aw_idx = s_axi_awaddr[OFS +: MEM_DEPTH_LOG2];
  assign ar_idx = s_axi_araddr[OFS +: MEM_DEPTH_LOG2];
  assign aw_legal = s_axi_awburst == 2'b01 && s_axi_awsize == 3'(OFS);
  assign ar_legal = s_axi_arburst == 2'b01 && s_axi_arsize == 3'(OFS);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign b_hs = s_axi_bvalid && s_axi_bready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs = s_axi_rvalid && s_axi_rready;
  assign w_final = w_cnt == w_len;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  always_comb begin
    w_next = aw_hs ? W_DATA : (w_hs && w_final) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_next = ar_hs ? R_DATA : (r_hs && s_axi_rlast) ? R_IDLE : r_state;
  end
  always_comb begin
    s_axi_awready = resetn && w_state == W_IDLE;
    s_axi_wready = w_state == W_DATA;
    s_axi_bvalid = w_state == W_RESP;
    s_axi_arready = resetn && r_state == R_IDLE;
    s_axi_rvalid = r_state == R_DATA;
  end
  // wlast is only checked against the beat count, never used to end the burst
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_axi_bid <= '0;
      s_axi_bresp <= 2'b00;
      w_idx <= '0;
      w_len <= 8'd0;
      w_cnt <= 8'd0;
      w_legal <= 1'b0;
      w_bad <= 1'b0;
      wr_burst_cnt <= 32'd0;
    end else begin
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        w_idx <= aw_idx;
        w_len <= s_axi_awlen;
        w_cnt <= 8'd0;
        w_legal <= aw_legal;
        w_bad <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + IDX_ONE;
        w_cnt <= w_cnt + 8'd1;
        if (s_axi_wlast != w_final) w_bad <= 1'b1;
      end
      if (w_hs && w_final) s_axi_bresp <= (!w_legal || w_bad || !s_axi_wlast) ? 2'b10 : 2'b00;
      if (b_hs) wr_burst_cnt <= wr_burst_cnt + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (resetn && w_hs && w_legal)
      for (int i = 0; i < SW; i++)
        if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
  end
  // reads are registered against the pre-write RAM contents, so a same-cycle write is not seen
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      s_axi_rlast <= 1'b0;
      r_idx <= '0;
      r_len <= 8'd0;
      r_cnt <= 8'd0;
      r_legal <= 1'b0;
      rd_burst_cnt <= 32'd0;
    end else begin
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        s_axi_rdata <= ar_legal ? mem[ar_idx] : '0;
        s_axi_rresp <= ar_legal ? 2'b00 : 2'b10;
        s_axi_rlast <= s_axi_arlen == 8'd0;
        r_idx <= ar_idx + IDX_ONE;
        r_len <= s_axi_arlen;
        r_cnt <= 8'd0;
        r_legal <= ar_legal;
      end
      if (r_hs && !s_axi_rlast) begin
        s_axi_rdata <= r_legal ? mem[r_idx] : '0;
        s_axi_rlast <= (r_cnt + 8'd1) == r_len;
        r_idx <= r_idx + IDX_ONE;
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_hs && s_axi_rlast) rd_burst_cnt <= rd_burst_cnt + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) err_sticky <= 1'b0;
    else if ((b_hs && s_axi_bresp == 2'b10) || (r_hs && s_axi_rresp == 2'b10)) err_sticky <= 1'b1;
  end
endmodule

// File: tb/tb_axi_host_mem_responder.sv
// tb_axi_host_mem_responder: table of bursts checked against a RAM model and response queues,
// plus hand-written mid-burst reset sequences.
module tb_axi_host_mem_responder;
  localparam int DW = 1024;
  localparam int SW = DW/8;
  localparam logic [SW-1:0] ALL = {SW{1'b1}};
  typedef struct {
    logic wr; logic [63:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    logic [4:0] id; logic [7:0] base; logic ff; logic [SW-1:0] strb; int wl; int rmode; logic [1:0] exp_resp;
  } rec_t;
  typedef struct { logic [DW-1:0] d; logic last; logic [1:0] resp; logic [4:0] id; } item_t;
  logic clk = 0, resetn;
  logic [4:0] awid, arid, bid, rid;
  logic [63:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready, err_sticky;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [31:0] wr_cnt, rd_cnt;
  logic [DW-1:0] mdl [64];
  item_t rq[$], bq[$];
  int n_chk = 0, n_err = 0, exp_wr = 0, exp_rd = 0;
  logic exp_err = 0;
  rec_t tbl[14];
  always #5 clk = ~clk;
  axi_host_mem_responder dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wr_burst_cnt(wr_cnt), .rd_burst_cnt(rd_cnt), .err_sticky(err_sticky)
  );
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", nm, act[127:0], exp[127:0]);
    end
  endtask
  task automatic wr(input rec_t r, input int abort);
    logic legal;
    logic [5:0] k;
    logic [DW-1:0] d;
    item_t eb;
    int n;
    legal = r.burst == 2'b01 && r.size == 3'd7;
    bq.push_back('{d: '0, last: 1'b0, resp: r.exp_resp, id: r.id});
    @(negedge clk);
    awid = r.id; awaddr = r.addr; awlen = r.len; awsize = r.size; awburst = r.burst; awvalid = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("awready", awready, 1);
    @(negedge clk);
    awvalid = 0;
    for (int b = 0; b <= int'(r.len); b++) begin
      d = r.ff ? {DW{1'b1}} : DW'(r.base + 8'(b));
      wdata = d; wstrb = r.strb; wlast = (b == r.wl); wvalid = 1;
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      chk("wready", wready, 1);
      k = r.addr[7 +: 6] + 6'(b);
      if (legal) for (int i = 0; i < SW; i++) if (r.strb[i]) mdl[k][i*8 +: 8] = d[i*8 +: 8];
      @(negedge clk);
      if (abort == b + 1) begin wvalid = 0; return; end
    end
    wvalid = 0; wlast = 0;
    chk("aw_blocked_in_resp", awready, 0);
    bready = 1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid", bvalid, 1);
    eb = bq.pop_front();
    chk("bid", bid, eb.id);
    chk("bresp", bresp, eb.resp);
    @(negedge clk);
    bready = 0;
    exp_wr++;
    if (eb.resp == 2'b10) exp_err = 1;
    chk("wr_burst_cnt", wr_cnt, exp_wr);
    chk("err_sticky_w", err_sticky, exp_err);
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask
  task automatic rd(input rec_t r, input int abort);
    logic legal;
    logic [5:0] k;
    item_t e;
    int b, n;
    logic tog;
    legal = r.burst == 2'b01 && r.size == 3'd7;
    for (int i = 0; i <= int'(r.len); i++) begin
      k = r.addr[7 +: 6] + 6'(i);
      rq.push_back('{d: legal ? mdl[k] : '0, last: i == int'(r.len), resp: r.exp_resp, id: r.id});
    end
    @(negedge clk);
    arid = r.id; araddr = r.addr; arlen = r.len; arsize = r.size; arburst = r.burst; arvalid = 1;
    chk("rvalid_before_ar", rvalid, 0);
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("arready", arready, 1);
    @(negedge clk);
    arvalid = 0;
    b = 0; n = 0; tog = 1;
    while (b <= int'(r.len) && n < 200) begin
      rready = r.rmode != 0 ? tog : 1'b1;
      tog = ~tog;
      chk("rvalid", rvalid, 1);
      if (rvalid) begin
        e = rq[0];
        chk("rid", rid, e.id);
        chk("rdata", rdata, e.d);
        chk("rlast", rlast, e.last);
        chk("rresp", rresp, e.resp);
        if (rready) begin void'(rq.pop_front()); b++; end
      end
      @(negedge clk);
      n++;
      if (abort == b) begin rready = 0; return; end
    end
    rready = 0;
    exp_rd++;
    if (r.exp_resp == 2'b10) exp_err = 1;
    chk("rd_burst_cnt", rd_cnt, exp_rd);
    chk("err_sticky_r", err_sticky, exp_err);
    chk("rvalid_drop", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask
  task automatic reset_check();
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err", err_sticky, 0);
    resetn = 1;
    rq.delete(); bq.delete();
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    @(negedge clk);
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    resetn = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    reset_check();
    tbl[0]  = '{1, 64'h0,     3, 7, 1, 5'd5,  8'hA0, 0, ALL,     3, 0, 2'b00};
    tbl[1]  = '{0, 64'h0,     3, 7, 1, 5'd6,  8'h00, 0, ALL,     0, 0, 2'b00};
    tbl[2]  = '{0, 64'h0,     3, 7, 1, 5'd7,  8'h00, 0, ALL,     0, 1, 2'b00};
    tbl[3]  = '{1, 64'd7936,  3, 7, 1, 5'd8,  8'hB0, 0, ALL,     3, 0, 2'b00};
    tbl[4]  = '{0, 64'd7936,  3, 7, 1, 5'd9,  8'h00, 0, ALL,     0, 0, 2'b00};
    tbl[5]  = '{1, 64'h280,   0, 7, 1, 5'd10, 8'h00, 1, ALL,     0, 0, 2'b00};
    tbl[6]  = '{1, 64'h280,   0, 7, 1, 5'd11, 8'h44, 0, 128'hF,  0, 0, 2'b00};
    tbl[7]  = '{0, 64'h280,   0, 7, 1, 5'd12, 8'h00, 0, ALL,     0, 0, 2'b00};
    tbl[8]  = '{1, 64'h0,     1, 7, 2, 5'd13, 8'hC0, 0, ALL,     1, 0, 2'b10};
    tbl[9]  = '{1, 64'hA00,   3, 7, 1, 5'd14, 8'hD0, 0, ALL,     1, 0, 2'b10};
    tbl[10] = '{0, 64'h0,     1, 7, 1, 5'd15, 8'h00, 0, ALL,     0, 0, 2'b00};
    tbl[11] = '{0, 64'h0,     2, 3, 1, 5'd16, 8'h00, 0, ALL,     0, 1, 2'b10};
    tbl[12] = '{0, 64'hA00,   3, 7, 1, 5'd17, 8'h00, 0, ALL,     0, 0, 2'b00};
    tbl[13] = '{0, 64'hFFFF_0000_0000_0280, 0, 7, 1, 5'd18, 8'h00, 0, ALL, 0, 0, 2'b00};
    foreach (tbl[i]) if (tbl[i].wr) wr(tbl[i], -1); else rd(tbl[i], -1);
    chk("word5_upper_ff", mdl[5][DW-1:32], {(DW-32){1'b1}});
    // abandon a read during its second beat
    rd('{0, 64'h0, 3, 7, 1, 5'd19, 8'h00, 0, ALL, 0, 0, 2'b00}, 1);
    resetn = 0;
    reset_check();
    // abandon a write after two of four beats; those two words must persist
    wr('{1, 64'hF00, 3, 7, 1, 5'd20, 8'hE0, 0, ALL, 3, 0, 2'b00}, 2);
    resetn = 0;
    reset_check();
    rd('{0, 64'hF00, 1, 7, 1, 5'd21, 8'h00, 0, ALL, 0, 0, 2'b00}, -1);
    rd('{0, 64'h0, 3, 7, 1, 5'd22, 8'h00, 0, ALL, 0, 1, 2'b00}, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
